// File: rtl/sdspi_n_pkg.sv
// sdspi_n_pkg: shared types for the parametrised SPI master sdspi_n.
//   spiOP_t     - sequencer command encodings (same values as the original sdspi)
//   spiMODE_t   - packed {CPOL,CPHA}
//   spiSPEED_t  - slow/fast SCLK divider selection
package sdspi_n_pkg;

  typedef enum logic [2:0] {
    spiNOP  = 3'd0,
    spiCSL  = 3'd1,
    spiCSH  = 3'd2,
    spiFAST = 3'd3,
    spiSLOW = 3'd4,
    spiTR   = 3'd5
  } spiOP_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spiMODE_t;

  typedef enum logic {
    SPD_SLOW = 1'b0,
    SPD_FAST = 1'b1
  } spiSPEED_t;

endpackage

// File: rtl/sdspi_n_if.sv
// sdspi_n_if: command/handshake and SPI pin bundle of sdspi_n.
//   master modport: sequencer/environment side (drives spiOP, spiSEL, spiMODE,
//                   spiTXD, spiMISO and, with SPI_LOOPBACK_EN, spiLOOP)
//   slave modport : the SPI master block (drives spiRXD, spiDONE, spiBUSY,
//                   spiCS, spiSCLK, spiMOSI)
// Optional feature macro: SPI_LOOPBACK_EN adds spiLOOP.
interface sdspi_n_if
  import sdspi_n_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NCS    = 1
) ();
  localparam int SELW = (NCS > 1) ? $clog2(NCS) : 1;

  spiOP_t              spiOP;
  logic [SELW-1:0]     spiSEL;
  spiMODE_t            spiMODE;
  logic [DATA_W-1:0]   spiTXD;
  logic [DATA_W-1:0]   spiRXD;
  logic                spiDONE;
  logic                spiBUSY;
  logic [NCS-1:0]      spiCS;
  logic                spiSCLK;
  logic                spiMOSI;
  logic                spiMISO;
`ifdef SPI_LOOPBACK_EN
  logic                spiLOOP;
`endif

  modport master (
    output spiOP, spiSEL, spiMODE, spiTXD, spiMISO,
`ifdef SPI_LOOPBACK_EN
    output spiLOOP,
`endif
    input  spiRXD, spiDONE, spiBUSY, spiCS, spiSCLK, spiMOSI
  );

  modport slave (
    input  spiOP, spiSEL, spiMODE, spiTXD, spiMISO,
`ifdef SPI_LOOPBACK_EN
    input  spiLOOP,
`endif
    output spiRXD, spiDONE, spiBUSY, spiCS, spiSCLK, spiMOSI
  );

endinterface

// File: rtl/sdspi_n_clkdiv.sv
// sdspi_clkdiv: SCLK half-period timer for sdspi_n.
//   clk, rst (sync, active-low), en (count while high, clear while low),
//   fast (selects FAST_DIV instead of SLOW_DIV), tick (one-cycle pulse every
//   DIV enabled cycles; first pulse on the DIV-th enabled cycle).
module sdspi_clkdiv #(
  parameter int SLOW_DIV = 64,
  parameter int FAST_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic fast,
  output logic tick
);
  localparam int MAXDIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  // A divide-by-1 still needs a one-bit counter to exist.
  localparam int CW = (MAXDIV > 1) ? $clog2(MAXDIV) : 1;
  localparam logic [CW-1:0] SLOW_TC = CW'(SLOW_DIV - 1);
  localparam logic [CW-1:0] FAST_TC = CW'(FAST_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] term_s;

  // Terminal-count selection and counter next value.
  always_comb begin
    term_s = fast ? FAST_TC : SLOW_TC;
    cnt_d  = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == term_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == term_s);

endmodule

// File: rtl/sdspi_n.sv
// sdspi_n: parametrised SPI master for the RK8E sequencer / SD card.
//   clk  : system clock, rising edge
//   rst  : synchronous, active-low reset
//   bus  : sdspi_n_if.slave - spiOP/spiSEL/spiMODE/spiTXD commands in,
//          spiRXD/spiDONE/spiBUSY status out, spiCS/spiSCLK/spiMOSI/spiMISO pins
// Parameters: DATA_W (8..32), NCS (1..8), SLOW_DIV, FAST_DIV (>=1).
// Optional feature macro: SPI_LOOPBACK_EN (internal MOSI->RX loopback, SCLK held).
module sdspi_n
  import sdspi_n_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NCS      = 1,
  parameter int SLOW_DIV = 64,
  parameter int FAST_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  sdspi_n_if.slave   bus
);
  localparam int BCW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_TRAIL = 2'd2,
    ST_DONE  = 2'd3
  } spiSTATE_t;

  spiSTATE_t         state_q, state_d;
  spiSPEED_t         speed_q, speed_d;
  spiMODE_t          mode_q, mode_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [BCW-1:0]    bits_q, bits_d;
  logic [NCS-1:0]    cs_q, cs_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic [DATA_W-1:0] rxd_q, rxd_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              tick_s;
  logic              rx_bit_s;
  logic              loop_s;

`ifdef SPI_LOOPBACK_EN
  logic loop_q, loop_d;

  // Loopback selection, latched with each accepted transfer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      loop_q <= 1'b0;
    end else begin
      loop_q <= loop_d;
    end
  end
  assign loop_s = loop_q;
`else
  assign loop_s = 1'b0;
`endif

  sdspi_clkdiv #(
    .SLOW_DIV (SLOW_DIV),
    .FAST_DIV (FAST_DIV)
  ) u_clkdiv (
    .clk  (clk),
    .rst  (rst),
    .en   ((state_q == ST_LEAD) || (state_q == ST_TRAIL)),
    .fast (speed_q == SPD_FAST),
    .tick (tick_s)
  );

  // Next-state and output logic of the transfer FSM.
  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    mode_d  = mode_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    bits_d  = bits_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    rxd_d   = rxd_q;
`ifdef SPI_LOOPBACK_EN
    loop_d  = loop_q;
`endif
    // In loopback the bit being driven on MOSI is what gets received.
    rx_bit_s = loop_s ? mosi_q : bus.spiMISO;

    case (state_q)
      ST_IDLE: begin
        sclk_d = bus.spiMODE.cpol;
        mosi_d = 1'b1;
        case (bus.spiOP)
          spiCSL: begin
            cs_d = '1;
            if (int'(bus.spiSEL) < NCS) begin
              cs_d[bus.spiSEL] = 1'b0;
            end else begin
              cs_d = '1;
            end
          end
          spiCSH:  cs_d    = '1;
          spiSLOW: speed_d = SPD_SLOW;
          spiFAST: speed_d = SPD_FAST;
          spiTR: begin
            state_d = ST_LEAD;
            mode_d  = bus.spiMODE;
            tx_d    = bus.spiTXD;
            bits_d  = BCW'(DATA_W);
            // CPHA=0 presents the MSB before the first edge; CPHA=1 waits for it.
            mosi_d  = bus.spiMODE.cpha ? 1'b1 : bus.spiTXD[DATA_W-1];
`ifdef SPI_LOOPBACK_EN
            loop_d  = bus.spiLOOP;
`endif
          end
          default: ;
        endcase
      end

      ST_LEAD: begin
        if (tick_s) begin
          state_d = ST_TRAIL;
          sclk_d  = loop_s ? mode_q.cpol : ~mode_q.cpol;
          if (mode_q.cpha) begin
            mosi_d = tx_q[DATA_W-1];
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
          end else begin
            rx_d = {rx_q[DATA_W-2:0], rx_bit_s};
          end
        end else begin
          state_d = ST_LEAD;
        end
      end

      ST_TRAIL: begin
        if (tick_s) begin
          sclk_d = mode_q.cpol;
          bits_d = bits_q - BCW'(1);
          if (mode_q.cpha) begin
            rx_d = {rx_q[DATA_W-2:0], rx_bit_s};
          end else if (bits_q != BCW'(1)) begin
            mosi_d = tx_q[DATA_W-2];
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
          end else begin
            // Last bit: hold MOSI so it is stable across the final edge.
            mosi_d = mosi_q;
          end
          if (bits_q == BCW'(1)) begin
            state_d = ST_DONE;
            rxd_d   = rx_d;
          end else begin
            state_d = ST_LEAD;
          end
        end else begin
          state_d = ST_TRAIL;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        sclk_d  = bus.spiMODE.cpol;
        mosi_d  = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_LEAD) || (state_d == ST_TRAIL);
    done_d = (state_d == ST_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      speed_q <= SPD_SLOW;
      mode_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      bits_q  <= '0;
      cs_q    <= '1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b1;
      rxd_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      speed_q <= speed_d;
      mode_q  <= mode_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      bits_q  <= bits_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      rxd_q   <= rxd_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.spiRXD  = rxd_q;
  assign bus.spiDONE = done_q;
  assign bus.spiBUSY = busy_q;
  assign bus.spiCS   = cs_q;
  assign bus.spiSCLK = sclk_q;
  assign bus.spiMOSI = mosi_q;

endmodule

// File: tb/tb_sdspi_n.sv
// tb_sdspi_n: directed, table-driven bench for sdspi_n
// (DATA_W=8, NCS=2, SLOW_DIV=4, FAST_DIV=1). A small SPI slave model watches
// SCLK edges, shifts MISO out and captures MOSI according to CPHA.
module tb_sdspi_n;
  import sdspi_n_pkg::*;

  localparam int DW    = 8;
  localparam int NCS_P = 2;
  localparam int SLOW  = 4;
  localparam int FAST  = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdspi_n_if #(.DATA_W(DW), .NCS(NCS_P)) bus ();

  sdspi_n #(
    .DATA_W   (DW),
    .NCS      (NCS_P),
    .SLOW_DIV (SLOW),
    .FAST_DIV (FAST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Slave model state
  logic [7:0] miso_pat  = 8'h00;
  logic [7:0] mosi_seen = 8'h00;
  int         edge_cnt  = 0;
  logic       prev_sclk = 1'b0;
  logic       cur_cpha  = 1'b0;

  typedef struct {
    spiOP_t     op;
    logic       sel;
    logic [1:0] cs;
  } cs_vec_t;

  typedef struct {
    spiOP_t     spd;
    logic [1:0] mode;
    logic [7:0] txd;
    logic [7:0] pat;
    int         lat;
    bit         probe;
  } xfer_vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // SPI slave: count SCLK edges; shift MISO out / capture MOSI per CPHA.
  always @(negedge clk) begin
    if (bus.spiSCLK !== prev_sclk) begin
      edge_cnt = edge_cnt + 1;
      if (!cur_cpha) begin
        if (edge_cnt % 2 == 1) mosi_seen = {mosi_seen[6:0], bus.spiMOSI};
        else if (edge_cnt < 16) bus.spiMISO = miso_pat[7 - edge_cnt / 2];
      end else begin
        if (edge_cnt % 2 == 1) bus.spiMISO = miso_pat[7 - (edge_cnt - 1) / 2];
        else mosi_seen = {mosi_seen[6:0], bus.spiMOSI};
      end
    end
    prev_sclk = bus.spiSCLK;
  end

  task automatic run_xfer(input spiOP_t spd, input logic [1:0] mode, input logic [7:0] txd,
                          input logic [7:0] pat, input int exp_lat, input bit probe,
                          input bit loop);
    int         cyc;
    logic [7:0] rx_before;
    bit         rx_stable;
    bus.spiMODE = spiMODE_t'(mode);
`ifdef SPI_LOOPBACK_EN
    bus.spiLOOP = loop;
`endif
    bus.spiOP = spd;
    step();
    bus.spiOP = spiNOP;
    step();
    step();
    chk("idle_sclk", {31'd0, bus.spiSCLK}, {31'd0, mode[1]});
    miso_pat    = pat;
    cur_cpha    = mode[0];
    edge_cnt    = 0;
    mosi_seen   = 8'h00;
    bus.spiMISO = pat[7];
    rx_before   = bus.spiRXD;
    rx_stable   = 1'b1;
    bus.spiTXD  = txd;
    bus.spiOP   = spiTR;
    step();
    bus.spiOP = spiNOP;
    cyc = 1;
    chk("busy_t1", {31'd0, bus.spiBUSY}, 32'd1);
    while (!bus.spiDONE && cyc < 200) begin
      if (bus.spiRXD !== rx_before) rx_stable = 1'b0;
      if (probe && cyc == 4) begin
        bus.spiOP  = spiCSL;
        bus.spiSEL = 1'b0;
      end else if (probe && cyc == 6) begin
        bus.spiOP  = spiTR;
        bus.spiTXD = 8'hFF;
      end else begin
        bus.spiOP = spiNOP;
      end
      step();
      cyc++;
    end
    bus.spiOP = spiNOP;
    chk("done_latency", cyc, exp_lat);
    chk("rxd", {24'd0, bus.spiRXD}, {24'd0, pat});
    chk("busy_at_done", {31'd0, bus.spiBUSY}, 32'd0);
    chk("rxd_stable", {31'd0, rx_stable}, 32'd1);
    // spiTR during the DONE pulse must be ignored
    bus.spiOP = spiTR;
    step();
    bus.spiOP = spiNOP;
    chk("tr_in_done_ignored", {31'd0, bus.spiBUSY}, 32'd0);
    chk("done_one_cycle", {31'd0, bus.spiDONE}, 32'd0);
    chk("sclk_edges", edge_cnt, loop ? 0 : 16);
    if (!loop) chk("mosi_bits", {24'd0, mosi_seen}, {24'd0, txd});
    if (probe) chk("cs_busy_ignored", {30'd0, bus.spiCS}, 32'd3);
  endtask

  initial begin
    cs_vec_t   cv[4];
    xfer_vec_t xv[4];
    bit        seen_done;

    cv[0] = '{spiCSL, 1'b1, 2'b01};
    cv[1] = '{spiCSH, 1'b0, 2'b11};
    cv[2] = '{spiCSL, 1'b0, 2'b10};
    cv[3] = '{spiCSH, 1'b1, 2'b11};

    xv[0] = '{spiSLOW, 2'b00, 8'h55, 8'hA3, 65, 1'b0};
    xv[1] = '{spiFAST, 2'b11, 8'hAA, 8'h0F, 17, 1'b1};
    xv[2] = '{spiFAST, 2'b01, 8'hC6, 8'h5A, 17, 1'b0};
    xv[3] = '{spiFAST, 2'b10, 8'h81, 8'hE7, 17, 1'b0};

    rst         = 1'b0;
    bus.spiOP   = spiNOP;
    bus.spiSEL  = 1'b0;
    bus.spiMODE = spiMODE_t'(2'b00);
    bus.spiTXD  = 8'h00;
    bus.spiMISO = 1'b1;
`ifdef SPI_LOOPBACK_EN
    bus.spiLOOP = 1'b0;
`endif
    repeat (5) step();
    chk("rst_cs",   {30'd0, bus.spiCS},   32'd3);
    chk("rst_sclk", {31'd0, bus.spiSCLK}, 32'd0);
    chk("rst_mosi", {31'd0, bus.spiMOSI}, 32'd1);
    chk("rst_rxd",  {24'd0, bus.spiRXD},  32'd0);
    chk("rst_busy", {31'd0, bus.spiBUSY}, 32'd0);
    rst = 1'b1;
    step();

    for (int i = 0; i < 4; i++) begin
      bus.spiSEL = cv[i].sel;
      bus.spiOP  = cv[i].op;
      step();
      bus.spiOP = spiNOP;
      chk("cs_cmd", {30'd0, bus.spiCS}, {30'd0, cv[i].cs});
    end

    for (int i = 0; i < 4; i++) begin
      run_xfer(xv[i].spd, xv[i].mode, xv[i].txd, xv[i].pat, xv[i].lat, xv[i].probe, 1'b0);
    end

    // Reset in the middle of a slow transfer
    bus.spiSEL = 1'b1;
    bus.spiOP  = spiCSL;
    step();
    bus.spiOP = spiSLOW;
    step();
    bus.spiOP   = spiNOP;
    bus.spiMODE = spiMODE_t'(2'b00);
    step();
    bus.spiTXD = 8'h96;
    bus.spiOP  = spiTR;
    step();
    bus.spiOP = spiNOP;
    repeat (19) step();
    rst = 1'b0;
    step();
    chk("mid_rst_cs",   {30'd0, bus.spiCS},   32'd3);
    chk("mid_rst_sclk", {31'd0, bus.spiSCLK}, 32'd0);
    chk("mid_rst_mosi", {31'd0, bus.spiMOSI}, 32'd1);
    chk("mid_rst_rxd",  {24'd0, bus.spiRXD},  32'd0);
    chk("mid_rst_busy", {31'd0, bus.spiBUSY}, 32'd0);
    chk("mid_rst_done", {31'd0, bus.spiDONE}, 32'd0);
    rst = 1'b1;
    seen_done = 1'b0;
    repeat (80) begin
      step();
      if (bus.spiDONE || bus.spiBUSY) seen_done = 1'b1;
    end
    chk("no_activity_after_rst", {31'd0, seen_done}, 32'd0);
    run_xfer(spiSLOW, 2'b00, 8'h69, 8'hC3, 65, 1'b0, 1'b0);

`ifdef SPI_LOOPBACK_EN
    run_xfer(spiFAST, 2'b00, 8'h3C, 8'h3C, 17, 1'b0, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
